pzcorebus_fifo: RTL and testbench

- Single-clock pzcorebus buffer with an independent FIFO per channel (command, write data, response); the next-generation counterpart of the async bus FIFO.
- Each channel depth is set separately; depth 0 gives a combinational pass-through.
- Optional store-and-forward alignment holds a write-type command until its whole write-data burst is buffered.
- Inserted between bus slaves and masters for rate decoupling, fabric-side burst integrity and flow-control retiming.

---
 rtl/pzcorebus_fifo_if.sv | 113 +++++++++++
 rtl/pzcorebus_fifo.sv | 236 +++++++++++++++++++++++
 tb/tb_pzcorebus_fifo.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pzcorebus_fifo_if.sv
// pzcorebus types, packing helpers and the bus interface shared by the FIFO and its neighbours.
// The config struct selects the profile and the largest write burst a master may issue.
package pzcorebus_pkg;
  typedef enum logic {
    PZCOREBUS_MEMORY = 1'b0,
    PZCOREBUS_CSR    = 1'b1
  } pzcorebus_profile_e;

  // max_burst_length of 0 means the full range of the length field
  typedef struct packed {
    pzcorebus_profile_e profile;
    logic [3:0]         max_burst_length;
  } pzcorebus_config_s;

  localparam int ID_WIDTH     = 4;
  localparam int ADDR_WIDTH   = 16;
  localparam int DATA_WIDTH   = 16;
  localparam int LENGTH_WIDTH = 3;

  localparam logic [1:0] CMD_NONE     = 2'd0;
  localparam logic [1:0] CMD_READ     = 2'd1;
  localparam logic [1:0] CMD_WRITE    = 2'd2;
  localparam logic [1:0] CMD_WRITE_NP = 2'd3;

  typedef struct packed {
    logic [1:0]              mcmd;
    logic [ID_WIDTH-1:0]     mid;
    logic [ADDR_WIDTH-1:0]   maddr;
    logic [LENGTH_WIDTH-1:0] mlength;
  } pzcorebus_command_s;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] mdata;
    logic                  mdata_last;
  } pzcorebus_write_data_s;

  typedef struct packed {
    logic                  sresp;
    logic [ID_WIDTH-1:0]   sid;
    logic [DATA_WIDTH-1:0] sdata;
    logic                  sresp_last;
  } pzcorebus_response_s;

  function automatic int max_burst_beats(input pzcorebus_config_s cfg);
    return (cfg.max_burst_length == 4'd0) ? (1 << LENGTH_WIDTH) : int'(cfg.max_burst_length);
  endfunction

  function automatic logic command_with_data(input logic [1:0] mcmd);
    return mcmd[1];
  endfunction

  function automatic pzcorebus_command_s pack_command(
    input logic [1:0]              mcmd,
    input logic [ID_WIDTH-1:0]     mid,
    input logic [ADDR_WIDTH-1:0]   maddr,
    input logic [LENGTH_WIDTH-1:0] mlength
  );
    return {mcmd, mid, maddr, mlength};
  endfunction

  function automatic pzcorebus_write_data_s pack_write_data(
    input logic [DATA_WIDTH-1:0] mdata,
    input logic                  mdata_last
  );
    return {mdata, mdata_last};
  endfunction

  function automatic pzcorebus_response_s pack_response(
    input logic                  sresp,
    input logic [ID_WIDTH-1:0]   sid,
    input logic [DATA_WIDTH-1:0] sdata,
    input logic                  sresp_last
  );
    return {sresp, sid, sdata, sresp_last};
  endfunction
endpackage

interface pzcorebus_if;
  logic                                  mcmd_valid;
  logic                                  scmd_accept;
  logic [1:0]                            mcmd;
  logic [pzcorebus_pkg::ID_WIDTH-1:0]     mid;
  logic [pzcorebus_pkg::ADDR_WIDTH-1:0]   maddr;
  logic [pzcorebus_pkg::LENGTH_WIDTH-1:0] mlength;
  logic                                  mdata_valid;
  logic                                  sdata_accept;
  logic [pzcorebus_pkg::DATA_WIDTH-1:0]   mdata;
  logic                                  mdata_last;
  logic                                  sresp_valid;
  logic                                  mresp_accept;
  logic                                  sresp;
  logic [pzcorebus_pkg::ID_WIDTH-1:0]     sid;
  logic [pzcorebus_pkg::DATA_WIDTH-1:0]   sdata;
  logic                                  sresp_last;

  modport master (
    output mcmd_valid, mcmd, mid, maddr, mlength,
    input  scmd_accept,
    output mdata_valid, mdata, mdata_last,
    input  sdata_accept,
    input  sresp_valid, sresp, sid, sdata, sresp_last,
    output mresp_accept
  );

  modport slave (
    input  mcmd_valid, mcmd, mid, maddr, mlength,
    output scmd_accept,
    input  mdata_valid, mdata, mdata_last,
    output sdata_accept,
    output sresp_valid, sresp, sid, sdata, sresp_last,
    input  mresp_accept
  );
endinterface

// File: rtl/pzcorebus_fifo.sv
// Single-clock pzcorebus buffer: one FIFO per channel, optional hold of write commands
// until their complete write-data burst is buffered.
module pzcorebus_fifo_channel #(
  parameter int WIDTH     = 1,
  parameter int DEPTH     = 2,
  parameter int THRESHOLD = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_push_valid,
  output logic             o_push_accept,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_pop_valid,
  input  logic             i_pop_accept,
  input  logic             i_pop_enable,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_empty,
  output logic             o_almost_full
);
  if (DEPTH == 0) begin : g_bypass
    assign o_pop_valid   = i_push_valid & i_pop_enable;
    assign o_push_accept = i_pop_accept & i_pop_enable;
    assign o_pop_data    = i_push_data;
    assign o_empty       = 1'b1;
    assign o_almost_full = 1'b0;
  end else begin : g_fifo
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty, full, push, pop;

    assign empty         = (count_q == '0);
    assign full          = (count_q == CW'(DEPTH));
    assign o_push_accept = !full;
    assign o_pop_valid   = !empty && i_pop_enable;
    assign push          = i_push_valid && o_push_accept;
    assign pop           = o_pop_valid && i_pop_accept;

    // explicit wrap keeps non-power-of-two depths correct
    always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else if (i_clear) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
      end
    end

    always_ff @(posedge i_clk) begin
      if (push && !i_clear) mem_q[wptr_q] <= i_push_data;
    end

    // stale storage is never exposed: payload reads as zero while empty
    assign o_pop_data    = empty ? '0 : mem_q[rptr_q];
    assign o_empty       = empty;
    assign o_almost_full = (32'(DEPTH) - 32'(count_q)) <= 32'(THRESHOLD);
  end
endmodule

module pzcorebus_fifo
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config_s BUS_CONFIG            = '0,
  parameter int                COMMAND_DEPTH         = 2,
  parameter int                DATA_DEPTH            = 2,
  parameter int                RESPONSE_DEPTH        = 2,
  parameter int                ALIGN_COMMAND_DATA    = 0,
  parameter int                ALMOST_FULL_THRESHOLD = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  output logic [2:0]        o_empty,
  output logic [2:0]        o_almost_full,
  pzcorebus_if.slave        slave_if,
  pzcorebus_if.master       master_if
);
  localparam bit IS_CSR      = (BUS_CONFIG.profile == PZCOREBUS_CSR);
  localparam int BURST_BEATS = max_burst_beats(BUS_CONFIG);

  if ((ALIGN_COMMAND_DATA != 0) && IS_CSR) begin : g_err_align_csr
    $fatal(1, "command/data alignment has no meaning without a write-data channel");
  end
  if ((ALIGN_COMMAND_DATA != 0) && (DATA_DEPTH < BURST_BEATS)) begin : g_err_align_depth
    $fatal(1, "data FIFO cannot hold a complete burst, alignment would deadlock");
  end

  pzcorebus_command_s    cmd_in, cmd_out;
  pzcorebus_response_s   resp_in, resp_out;
  logic                  cmd_release;

  assign cmd_in = pack_command(slave_if.mcmd, slave_if.mid, slave_if.maddr, slave_if.mlength);

  pzcorebus_fifo_channel #(
    .WIDTH     ($bits(pzcorebus_command_s)),
    .DEPTH     (COMMAND_DEPTH),
    .THRESHOLD (ALMOST_FULL_THRESHOLD)
  ) u_cmd_fifo (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clear       (i_clear),
    .i_push_valid  (slave_if.mcmd_valid),
    .o_push_accept (slave_if.scmd_accept),
    .i_push_data   (cmd_in),
    .o_pop_valid   (master_if.mcmd_valid),
    .i_pop_accept  (master_if.scmd_accept),
    .i_pop_enable  (cmd_release),
    .o_pop_data    (cmd_out),
    .o_empty       (o_empty[0]),
    .o_almost_full (o_almost_full[0])
  );

  assign master_if.mcmd    = cmd_out.mcmd;
  assign master_if.mid     = cmd_out.mid;
  assign master_if.maddr   = cmd_out.maddr;
  assign master_if.mlength = cmd_out.mlength;

  if (IS_CSR) begin : g_no_data
    assign master_if.mdata_valid = 1'b0;
    assign master_if.mdata       = '0;
    assign master_if.mdata_last  = 1'b0;
    assign slave_if.sdata_accept = 1'b0;
    assign o_empty[1]            = 1'b1;
    assign o_almost_full[1]      = 1'b0;
  end else begin : g_data
    pzcorebus_write_data_s data_in, data_out;

    assign data_in = pack_write_data(slave_if.mdata, slave_if.mdata_last);

    pzcorebus_fifo_channel #(
      .WIDTH     ($bits(pzcorebus_write_data_s)),
      .DEPTH     (DATA_DEPTH),
      .THRESHOLD (ALMOST_FULL_THRESHOLD)
    ) u_data_fifo (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_clear       (i_clear),
      .i_push_valid  (slave_if.mdata_valid),
      .o_push_accept (slave_if.sdata_accept),
      .i_push_data   (data_in),
      .o_pop_valid   (master_if.mdata_valid),
      .i_pop_accept  (master_if.sdata_accept),
      .i_pop_enable  (1'b1),
      .o_pop_data    (data_out),
      .o_empty       (o_empty[1]),
      .o_almost_full (o_almost_full[1])
    );

    assign master_if.mdata      = data_out.mdata;
    assign master_if.mdata_last = data_out.mdata_last;
  end

  if (ALIGN_COMMAND_DATA != 0) begin : g_align
    localparam int BW = $clog2(DATA_DEPTH + 1);

    logic [BW-1:0] burst_count_q, burst_count_d;
    logic          burst_inc, burst_dec;

    // complete bursts sitting in the data FIFO that no command has claimed yet
    assign burst_inc = slave_if.mdata_valid && slave_if.sdata_accept && slave_if.mdata_last;
    assign burst_dec = master_if.mcmd_valid && master_if.scmd_accept && command_with_data(cmd_out.mcmd);

    always_comb begin
      burst_count_d = burst_count_q;
      if (burst_inc && !burst_dec)      burst_count_d = burst_count_q + 1'b1;
      else if (burst_dec && !burst_inc) burst_count_d = burst_count_q - 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     burst_count_q <= '0;
      else if (i_clear) burst_count_q <= '0;
      else              burst_count_q <= burst_count_d;
    end

    // a write at the head blocks everything behind it until its burst is complete
    assign cmd_release = !command_with_data(cmd_out.mcmd) || (burst_count_q != '0);

    a_burst_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n || i_clear)
      !(burst_inc && !burst_dec && (burst_count_q == BW'(DATA_DEPTH))));
    a_burst_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n || i_clear)
      !(burst_dec && !burst_inc && (burst_count_q == '0)));
  end else begin : g_no_align
    assign cmd_release = 1'b1;
  end

  assign resp_in = pack_response(master_if.sresp, master_if.sid, master_if.sdata, master_if.sresp_last);

  pzcorebus_fifo_channel #(
    .WIDTH     ($bits(pzcorebus_response_s)),
    .DEPTH     (RESPONSE_DEPTH),
    .THRESHOLD (ALMOST_FULL_THRESHOLD)
  ) u_resp_fifo (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clear       (i_clear),
    .i_push_valid  (master_if.sresp_valid),
    .o_push_accept (master_if.mresp_accept),
    .i_push_data   (resp_in),
    .o_pop_valid   (slave_if.sresp_valid),
    .i_pop_accept  (slave_if.mresp_accept),
    .i_pop_enable  (1'b1),
    .o_pop_data    (resp_out),
    .o_empty       (o_empty[2]),
    .o_almost_full (o_almost_full[2])
  );

  assign slave_if.sresp      = resp_out.sresp;
  assign slave_if.sid        = resp_out.sid;
  assign slave_if.sdata      = resp_out.sdata;
  assign slave_if.sresp_last = resp_out.sresp_last;
endmodule

// File: tb/tb_pzcorebus_fifo.sv
// Drives a plain FIFO instance and an aligned instance with identical stimulus, each checked
// against its own queue model; a third instance checks the all-bypass configuration.
module tb_pzcorebus_fifo;
  import pzcorebus_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [2:0] empty0, af0, empty1, af1, empty2, af2;

  always #5 clk = ~clk;

  pzcorebus_if up0(), dn0(), up1(), dn1(), up2(), dn2();

  pzcorebus_fifo u_dut_plain (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
    .o_empty(empty0), .o_almost_full(af0), .slave_if(up0), .master_if(dn0)
  );

  pzcorebus_fifo #(.COMMAND_DEPTH(4), .DATA_DEPTH(8), .ALIGN_COMMAND_DATA(1)) u_dut_align (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
    .o_empty(empty1), .o_almost_full(af1), .slave_if(up1), .master_if(dn1)
  );

  pzcorebus_fifo #(.COMMAND_DEPTH(0), .DATA_DEPTH(0), .RESPONSE_DEPTH(0)) u_dut_bypass (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
    .o_empty(empty2), .o_almost_full(af2), .slave_if(up2), .master_if(dn2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  localparam int CDEP [2]  = '{2, 4};
  localparam int DDEP [2]  = '{2, 8};
  localparam int RDEP      = 2;
  localparam bit ALIGN [2] = '{1'b0, 1'b1};

  pzcorebus_command_s    cq [2][$];
  pzcorebus_write_data_s dq [2][$];
  pzcorebus_response_s   rq [2][$];
  int                    bursts [2];

  typedef struct {
    logic                  cv, cacc, dv, dacc, rv, racc;
    logic [2:0]            empty, af;
    pzcorebus_command_s    cmd;
    pzcorebus_write_data_s dat;
    pzcorebus_response_s   resp;
  } obs_t;

  function automatic bit is_write(input pzcorebus_command_s c);
    return c.mcmd inside {CMD_WRITE, CMD_WRITE_NP};
  endfunction

  function automatic pzcorebus_command_s mk_cmd(input logic [1:0] t, input int len);
    pzcorebus_command_s c;
    c.mcmd    = t;
    c.mid     = 4'($urandom);
    c.maddr   = 16'($urandom);
    c.mlength = 3'(len);
    return c;
  endfunction

  function automatic pzcorebus_write_data_s mk_data(input logic last);
    pzcorebus_write_data_s d;
    d.mdata      = 16'($urandom);
    d.mdata_last = last;
    return d;
  endfunction

  function automatic pzcorebus_response_s mk_resp();
    pzcorebus_response_s r;
    r = pzcorebus_response_s'($urandom);
    return r;
  endfunction

  task automatic drive_side(input logic cv, ca, dv, da, rv, ra,
                            input pzcorebus_command_s c, input pzcorebus_write_data_s dt,
                            input pzcorebus_response_s r);
    up0.mcmd_valid = cv; up0.mcmd = c.mcmd; up0.mid = c.mid; up0.maddr = c.maddr; up0.mlength = c.mlength;
    up1.mcmd_valid = cv; up1.mcmd = c.mcmd; up1.mid = c.mid; up1.maddr = c.maddr; up1.mlength = c.mlength;
    up0.mdata_valid = dv; up0.mdata = dt.mdata; up0.mdata_last = dt.mdata_last;
    up1.mdata_valid = dv; up1.mdata = dt.mdata; up1.mdata_last = dt.mdata_last;
    up0.mresp_accept = ra; up1.mresp_accept = ra;
    dn0.scmd_accept = ca; dn1.scmd_accept = ca;
    dn0.sdata_accept = da; dn1.sdata_accept = da;
    dn0.sresp_valid = rv; dn0.sresp = r.sresp; dn0.sid = r.sid; dn0.sdata = r.sdata; dn0.sresp_last = r.sresp_last;
    dn1.sresp_valid = rv; dn1.sresp = r.sresp; dn1.sid = r.sid; dn1.sdata = r.sdata; dn1.sresp_last = r.sresp_last;
  endtask

  // one clock of stimulus on both buffered instances, checked before the edge, model updated at it
  task automatic step(input logic clr, cv, ca, dv, da, rv, ra,
                      input pzcorebus_command_s c, input pzcorebus_write_data_s dt,
                      input pzcorebus_response_s r);
    obs_t o [2];
    bit   pc [2], oc [2], pd [2], od [2], pr [2], orr [2];
    @(negedge clk);
    clear = clr;
    drive_side(cv, ca, dv, da, rv, ra, c, dt, r);
    #1;
    o[0] = '{dn0.mcmd_valid, up0.scmd_accept, dn0.mdata_valid, up0.sdata_accept, up0.sresp_valid,
             dn0.mresp_accept, empty0, af0, {dn0.mcmd, dn0.mid, dn0.maddr, dn0.mlength},
             {dn0.mdata, dn0.mdata_last}, {up0.sresp, up0.sid, up0.sdata, up0.sresp_last}};
    o[1] = '{dn1.mcmd_valid, up1.scmd_accept, dn1.mdata_valid, up1.sdata_accept, up1.sresp_valid,
             dn1.mresp_accept, empty1, af1, {dn1.mcmd, dn1.mid, dn1.maddr, dn1.mlength},
             {dn1.mdata, dn1.mdata_last}, {up1.sresp, up1.sid, up1.sdata, up1.sresp_last}};
    for (int d = 0; d < 2; d++) begin
      bit e_cv, e_cacc, e_dv, e_dacc, e_rv, e_racc;
      e_cv   = (cq[d].size() > 0) && (!ALIGN[d] || !is_write(cq[d][0]) || bursts[d] > 0);
      e_cacc = cq[d].size() < CDEP[d];
      e_dv   = dq[d].size() > 0;
      e_dacc = dq[d].size() < DDEP[d];
      e_rv   = rq[d].size() > 0;
      e_racc = rq[d].size() < RDEP;
      check_val($sformatf("d%0d mcmd_valid", d), 64'(o[d].cv), 64'(e_cv));
      check_val($sformatf("d%0d scmd_accept", d), 64'(o[d].cacc), 64'(e_cacc));
      check_val($sformatf("d%0d mdata_valid", d), 64'(o[d].dv), 64'(e_dv));
      check_val($sformatf("d%0d sdata_accept", d), 64'(o[d].dacc), 64'(e_dacc));
      check_val($sformatf("d%0d sresp_valid", d), 64'(o[d].rv), 64'(e_rv));
      check_val($sformatf("d%0d mresp_accept", d), 64'(o[d].racc), 64'(e_racc));
      check_val($sformatf("d%0d empty", d), 64'(o[d].empty),
                64'({rq[d].size() == 0, dq[d].size() == 0, cq[d].size() == 0}));
      check_val($sformatf("d%0d almost_full", d), 64'(o[d].af),
                64'({RDEP - rq[d].size() <= 1, DDEP[d] - dq[d].size() <= 1, CDEP[d] - cq[d].size() <= 1}));
      check_val($sformatf("d%0d cmd_payload", d), 64'(o[d].cmd), (cq[d].size() > 0) ? 64'(cq[d][0]) : 64'd0);
      check_val($sformatf("d%0d data_payload", d), 64'(o[d].dat), (dq[d].size() > 0) ? 64'(dq[d][0]) : 64'd0);
      check_val($sformatf("d%0d resp_payload", d), 64'(o[d].resp), (rq[d].size() > 0) ? 64'(rq[d][0]) : 64'd0);
      pc[d] = cv && e_cacc;  oc[d]  = e_cv && ca;
      pd[d] = dv && e_dacc;  od[d]  = e_dv && da;
      pr[d] = rv && e_racc;  orr[d] = e_rv && ra;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (clr || !rst_n) begin
        cq[d].delete(); dq[d].delete(); rq[d].delete(); bursts[d] = 0;
      end else begin
        if (oc[d]) begin
          if (ALIGN[d] && is_write(cq[d][0])) bursts[d]--;
          void'(cq[d].pop_front());
        end
        if (pc[d]) cq[d].push_back(c);
        if (od[d]) void'(dq[d].pop_front());
        if (pd[d]) begin
          dq[d].push_back(dt);
          if (ALIGN[d] && dt.mdata_last) bursts[d]++;
        end
        if (orr[d]) void'(rq[d].pop_front());
        if (pr[d]) rq[d].push_back(r);
      end
    end
  endtask

  task automatic idle(input logic ca, input logic da, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, ca, 1'b0, da, 1'b0, 1'b1, '0, '0, '0);
  endtask

  initial begin
    pzcorebus_command_s    c;
    pzcorebus_write_data_s dt;
    rst_n = 1'b0;
    clear = 1'b0;
    bursts[0] = 0;
    bursts[1] = 0;
    drive_side(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    idle(1'b0, 1'b0, 2);
    rst_n = 1'b1;
    idle(1'b0, 1'b0, 1);

    // three back-to-back reads against a stalled downstream, then drain
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk_cmd(CMD_READ, 0), '0, '0);
    idle(1'b1, 1'b1, 5);

    // write with 4-beat burst at cycle 0, read behind it, beats in cycles 5..8
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, mk_cmd(CMD_WRITE, 3), '0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, mk_cmd(CMD_READ, 0), '0, '0);
    idle(1'b1, 1'b1, 3);
    for (int b = 0; b < 4; b++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0, mk_data(b == 3), '0);
    idle(1'b1, 1'b1, 5);

    // flush with commands and beats buffered; push/pop in the clear cycle are dropped
    for (int i = 0; i < 3; i++)
      step(1'b0, i < 2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, mk_cmd(CMD_WRITE, 2), mk_data(i == 2), mk_resp());
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, mk_cmd(CMD_READ, 0), mk_data(1'b1), mk_resp());
    idle(1'b1, 1'b1, 3);

    for (int i = 0; i < 300; i++) begin
      c  = mk_cmd(2'($urandom_range(1, 3)), $urandom_range(0, 7));
      dt = mk_data($urandom_range(0, 2) == 0);
      if (bursts[1] >= 8) dt.mdata_last = 1'b0;
      step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 2) != 0,
           c, dt, mk_resp());
    end

    for (int i = 0; i < 20; i++) begin
      logic                  cv, ca, dv, da, rv, ra;
      pzcorebus_response_s   r;
      @(negedge clk);
      cv = 1'($urandom); ca = 1'($urandom); dv = 1'($urandom);
      da = 1'($urandom); rv = 1'($urandom); ra = 1'($urandom);
      c = mk_cmd(2'($urandom), $urandom_range(0, 7));
      dt = mk_data(1'($urandom));
      r = mk_resp();
      up2.mcmd_valid = cv; up2.mcmd = c.mcmd; up2.mid = c.mid; up2.maddr = c.maddr; up2.mlength = c.mlength;
      up2.mdata_valid = dv; up2.mdata = dt.mdata; up2.mdata_last = dt.mdata_last; up2.mresp_accept = ra;
      dn2.scmd_accept = ca; dn2.sdata_accept = da;
      dn2.sresp_valid = rv; dn2.sresp = r.sresp; dn2.sid = r.sid; dn2.sdata = r.sdata; dn2.sresp_last = r.sresp_last;
      #1;
      check_val("byp mcmd_valid", 64'(dn2.mcmd_valid), 64'(cv));
      check_val("byp scmd_accept", 64'(up2.scmd_accept), 64'(ca));
      check_val("byp cmd_payload", 64'({dn2.mcmd, dn2.mid, dn2.maddr, dn2.mlength}), 64'(c));
      check_val("byp mdata_valid", 64'(dn2.mdata_valid), 64'(dv));
      check_val("byp sdata_accept", 64'(up2.sdata_accept), 64'(da));
      check_val("byp data_payload", 64'({dn2.mdata, dn2.mdata_last}), 64'(dt));
      check_val("byp sresp_valid", 64'(up2.sresp_valid), 64'(rv));
      check_val("byp mresp_accept", 64'(dn2.mresp_accept), 64'(ra));
      check_val("byp resp_payload", 64'({up2.sresp, up2.sid, up2.sdata, up2.sresp_last}), 64'(r));
      check_val("byp empty", 64'(empty2), 64'd7);
      check_val("byp almost_full", 64'(af2), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
